// File: rtl/div_8.sv
// Sequential 8-bit restoring divider, one quotient bit per cycle, results held until the next run.
// Define DIV_SIGNED_EN for two's-complement operands; by default the divider is unsigned only.
module div_8 (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic [7:0] Dividend,
    input  logic [7:0] Divisor,
    output logic [7:0] Quotient,
    output logic [7:0] Remainder,
    output logic       Busy,
    output logic       Done,
    output logic       DivByZero
);

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    state_t     state_q, state_d;
    logic [8:0] r_q, r_d;
    logic [7:0] q_q, q_d;
    logic [7:0] d_q, d_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] quot_q, quot_d;
    logic [7:0] rem_q, rem_d;
    logic       dbz_q, dbz_d;

    logic [9:0] trial;
    logic [8:0] r_nx;
    logic [7:0] q_nx;
    logic [7:0] dvd_mag, dvs_mag;
    logic [7:0] quot_fix, rem_fix;

`ifdef DIV_SIGNED_EN
    logic sn_q, sn_d;
    logic sd_q, sd_d;

    // Core runs on magnitudes; signs are reapplied when the result is loaded.
    always_comb begin
        dvd_mag  = Dividend[7] ? -Dividend : Dividend;
        dvs_mag  = Divisor[7] ? -Divisor : Divisor;
        quot_fix = (sn_q ^ sd_q) ? -q_nx : q_nx;
        rem_fix  = sn_q ? -r_nx[7:0] : r_nx[7:0];
    end
`else
    always_comb begin
        dvd_mag  = Dividend;
        dvs_mag  = Divisor;
        quot_fix = q_nx;
        rem_fix  = r_nx[7:0];
    end
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
`ifdef DIV_SIGNED_EN
            sn_q    <= 1'b0;
            sd_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
`ifdef DIV_SIGNED_EN
            sn_q    <= sn_d;
            sd_q    <= sd_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (Run) state_d = (Divisor == 8'h00) ? DONE : ITER;
            ITER: if (cnt_q == 3'd7) state_d = DONE;
            DONE: if (!Run) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // One restoring step: the sign of the 10-bit trial picks subtract or keep.
    always_comb begin
        trial = {r_q, q_q[7]} - {2'b00, d_q};
        r_nx  = trial[9] ? {r_q[7:0], q_q[7]} : trial[8:0];
        q_nx  = {q_q[6:0], ~trial[9]};
    end

    always_comb begin
        r_d    = r_q;
        q_d    = q_q;
        d_d    = d_q;
        cnt_d  = cnt_q;
        quot_d = quot_q;
        rem_d  = rem_q;
        dbz_d  = dbz_q;
`ifdef DIV_SIGNED_EN
        sn_d   = sn_q;
        sd_d   = sd_q;
`endif
        if (state_q == IDLE && Run) begin
            if (Divisor == 8'h00) begin
                quot_d = 8'hFF;
                rem_d  = Dividend;
                dbz_d  = 1'b1;
            end else begin
                r_d   = '0;
                q_d   = dvd_mag;
                d_d   = dvs_mag;
                cnt_d = '0;
`ifdef DIV_SIGNED_EN
                sn_d  = Dividend[7];
                sd_d  = Divisor[7];
`endif
            end
        end else if (state_q == ITER) begin
            r_d   = r_nx;
            q_d   = q_nx;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
                quot_d = quot_fix;
                rem_d  = rem_fix;
                dbz_d  = 1'b0;
            end
        end
    end

    always_comb begin
        Busy      = (state_q == ITER);
        Done      = (state_q == DONE);
        Quotient  = quot_q;
        Remainder = rem_q;
        DivByZero = dbz_q;
    end

endmodule

// File: tb/tb_div_8.sv
// Self-checking bench for div_8: directed table, corner sequences and random operands
// against an arithmetic reference model.
module tb_div_8;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Run;
    logic [7:0] Dividend;
    logic [7:0] Divisor;
    logic [7:0] Quotient;
    logic [7:0] Remainder;
    logic       Busy;
    logic       Done;
    logic       DivByZero;

    div_8 dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Run       (Run),
        .Dividend  (Dividend),
        .Divisor   (Divisor),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .Busy      (Busy),
        .Done      (Done),
        .DivByZero (DivByZero)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       z;
    } vec_t;

    int pass_n = 0;
    int tot_n  = 0;

    logic [7:0] held_q = 8'h00;
    logic [7:0] held_r = 8'h00;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tot_n++;
        if (act === exp) pass_n++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic void model(input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] q, output logic [7:0] r,
                                  output logic z);
        int sa, sb;
        z = (b == 8'h00);
        if (z) begin
            q = 8'hFF;
            r = a;
        end else begin
`ifdef DIV_SIGNED_EN
            sa = int'($signed(a));
            sb = int'($signed(b));
`else
            sa = int'(a);
            sb = int'(b);
`endif
            q = 8'(sa / sb);
            r = 8'(sa % sb);
        end
    endfunction

    // Runs one division; hold = extra cycles Run stays high in DONE,
    // chg = scramble operands while iterating.
    task automatic run_div(input string nm, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] eq, input logic [7:0] er, input logic ez,
                           input int hold, input bit chg);
        int  k;
        int  busy_n;
        bit  seen;
        bit  bad;
        @(negedge Clk);
        Run      = 1'b1;
        Dividend = a;
        Divisor  = b;
        busy_n   = 0;
        seen     = 1'b0;
        bad      = 1'b0;
        for (k = 1; k <= 20; k++) begin
            @(negedge Clk);
            if (Done) begin
                seen = 1'b1;
                break;
            end
            if (Busy) busy_n++;
            if (Quotient !== held_q || Remainder !== held_r) bad = 1'b1;
            if (chg) begin
                Dividend = 8'($urandom);
                Divisor  = 8'($urandom);
            end
        end
        chk({nm, " latency"}, seen ? k : 0, ez ? 1 : 9);
        chk({nm, " busy_cycles"}, busy_n, ez ? 0 : 8);
        chk({nm, " prev_held"}, bad, 0);
        chk({nm, " busy_at_done"}, Busy, 0);
        chk({nm, " quotient"}, Quotient, eq);
        chk({nm, " remainder"}, Remainder, er);
        chk({nm, " divbyzero"}, DivByZero, ez);
        bad = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge Clk);
            if (!Done || Busy || Quotient !== eq || Remainder !== er) bad = 1'b1;
        end
        if (hold > 0) chk({nm, " no_retrigger"}, bad, 0);
        Run = 1'b0;
        @(negedge Clk);
        chk({nm, " done_fall"}, Done, 0);
        chk({nm, " idle_hold"}, {Quotient, Remainder}, {eq, er});
        held_q = eq;
        held_r = er;
    endtask

    vec_t tbl[6];

    initial begin
        logic [7:0] mq, mr;
        logic       mz;
        logic [7:0] ra, rb;

        Reset    = 1'b1;
        Run      = 1'b0;
        Dividend = 8'h00;
        Divisor  = 8'h00;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        chk("reset outputs", {Quotient, Remainder, Busy, Done, DivByZero}, 19'h0);
        Reset = 1'b0;

`ifdef DIV_SIGNED_EN
        tbl[0] = '{8'h9C, 8'h07, 8'hF2, 8'hFE, 1'b0};
        tbl[1] = '{8'h80, 8'hFF, 8'h80, 8'h00, 1'b0};
        tbl[2] = '{8'h64, 8'hF9, 8'hF2, 8'h02, 1'b0};
        tbl[3] = '{8'hB3, 8'h00, 8'hFF, 8'hB3, 1'b1};
        tbl[4] = '{8'h7F, 8'h01, 8'h7F, 8'h00, 1'b0};
        tbl[5] = '{8'hF6, 8'hFD, 8'h03, 8'hFF, 1'b0};
`else
        tbl[0] = '{8'hC8, 8'h07, 8'h1C, 8'h04, 1'b0};
        tbl[1] = '{8'hFF, 8'h01, 8'hFF, 8'h00, 1'b0};
        tbl[2] = '{8'h05, 8'h09, 8'h00, 8'h05, 1'b0};
        tbl[3] = '{8'h4D, 8'h00, 8'hFF, 8'h4D, 1'b1};
        tbl[4] = '{8'h64, 8'h0A, 8'h0A, 8'h00, 1'b0};
        tbl[5] = '{8'hFF, 8'hFF, 8'h01, 8'h00, 1'b0};
`endif

        for (int i = 0; i < 6; i++)
            run_div($sformatf("vec%0d", i), tbl[i].a, tbl[i].b,
                    tbl[i].q, tbl[i].r, tbl[i].z, (i == 0) ? 3 : 0, 1'b0);

        // Abort mid-iteration: reset lands on E5, one edge after E4.
        @(negedge Clk);
        Run      = 1'b1;
        Dividend = tbl[0].a;
        Divisor  = tbl[0].b;
        repeat (5) @(posedge Clk);
        @(negedge Clk);
        chk("abort busy_before", Busy, 1);
        Reset = 1'b1;
        Run   = 1'b0;
        @(negedge Clk);
        chk("abort outputs", {Quotient, Remainder, Busy, Done, DivByZero}, 19'h0);
        Reset  = 1'b0;
        held_q = 8'h00;
        held_r = 8'h00;
        @(negedge Clk);
        chk("abort stays_idle", {Busy, Done}, 2'b00);
        run_div("after_abort", tbl[4].a, tbl[4].b, tbl[4].q, tbl[4].r, tbl[4].z, 0, 1'b0);

        // Run held through DONE while operands move during iteration.
        run_div("held_run", tbl[0].a, tbl[0].b, tbl[0].q, tbl[0].r, tbl[0].z, 20, 1'b1);

        for (int n = 0; n < 30; n++) begin
            ra = 8'($urandom);
            rb = (n % 7 == 3) ? 8'h00 : 8'($urandom);
            model(ra, rb, mq, mr, mz);
            run_div($sformatf("rand%0d %0h/%0h", n, ra, rb), ra, rb, mq, mr, mz,
                    n % 3, n[0]);
        end

        $display("%0d/%0d checks passed", pass_n, tot_n);
        $finish;
    end

endmodule
